mult_arbiter: RTL and testbench

MULT_ARBITER -- requirements
Module: mult_arbiter

---
 rtl/mult_arb_pkg.sv | 20 ++
 rtl/mult_arbiter_mult.sv | 17 +
 rtl/mult_arbiter.sv | 143 ++++++++++++++
 tb/tb_mult_arbiter.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mult_arb_pkg.sv
// Shared sizing for the multiplier arbiter: default widths and the helpers that size
// the requester ID and the round-robin pointer.
package mult_arb_pkg;

  localparam int DEF_BITWIDTH = 32;
  localparam int DEF_NUM_REQ  = 4;

  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // The pointer addresses the same index space as a grant ID.
  function automatic int ptr_width(input int n);
    return id_width(n);
  endfunction

  localparam int DEF_ID_W  = id_width(DEF_NUM_REQ);
  localparam int DEF_PTR_W = ptr_width(DEF_NUM_REQ);

endpackage

// File: rtl/mult_arbiter_mult.sv
// Shared unsigned multiplier datapath: full-width product of two BITWIDTH operands.
module mult_arbiter_mult
  import mult_arb_pkg::*;
#(
  parameter int BITWIDTH = DEF_BITWIDTH
) (
  input  logic [BITWIDTH-1:0]   i_a,
  input  logic [BITWIDTH-1:0]   i_b,
  output logic [2*BITWIDTH-1:0] o_y
);

  localparam int PW = 2 * BITWIDTH;

  // Widen before multiplying so the product is computed at full width.
  assign o_y = PW'(i_a) * PW'(i_b);

endmodule

// File: rtl/mult_arbiter.sv
// Round-robin arbiter sharing one multiplier among NUM_REQ requesters.
// Define MULT_ARB_OUT_REG_EN to add a registered output stage (latency 2 instead of 1).
module mult_arbiter
  import mult_arb_pkg::*;
#(
  parameter int BITWIDTH = DEF_BITWIDTH,
  parameter int NUM_REQ  = DEF_NUM_REQ
) (
  input  logic                        sys_clk,
  input  logic                        sys_rst_n,
  input  logic [NUM_REQ-1:0]          req_valid,
  output logic [NUM_REQ-1:0]          req_ready,
  input  logic [NUM_REQ*BITWIDTH-1:0] req_a,
  input  logic [NUM_REQ*BITWIDTH-1:0] req_b,
  output logic [NUM_REQ-1:0]          resp_valid,
  output logic [id_width(NUM_REQ)-1:0] resp_id,
  output logic [2*BITWIDTH-1:0]       resp_y
);

  localparam int ID_W  = id_width(NUM_REQ);
  localparam int PTR_W = ptr_width(NUM_REQ);

  logic [PTR_W-1:0]      r_rr_ptr;
  logic [NUM_REQ-1:0]    w_ready;
  logic [ID_W-1:0]       w_gnt_idx;
  logic                  w_found;
  logic                  w_accept;
  logic [BITWIDTH-1:0]   w_a;
  logic [BITWIDTH-1:0]   w_b;
  logic                  r_vld_p0;
  logic [ID_W-1:0]       r_id_p0;
  logic [BITWIDTH-1:0]   r_a_p0;
  logic [BITWIDTH-1:0]   r_b_p0;
  logic [2*BITWIDTH-1:0] w_y;
  logic                  w_vld_out;
  logic [ID_W-1:0]       w_id_out;

  // First pass searches at/above the pointer; second pass wraps to the lowest index.
  always_comb begin
    w_ready   = '0;
    w_gnt_idx = '0;
    w_found   = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!w_found && req_valid[i] && (ID_W'(i) >= r_rr_ptr)) begin
        w_found   = 1'b1;
        w_gnt_idx = ID_W'(i);
        w_ready   = '0;
        w_ready[i] = 1'b1;
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!w_found && req_valid[i]) begin
        w_found   = 1'b1;
        w_gnt_idx = ID_W'(i);
        w_ready   = '0;
        w_ready[i] = 1'b1;
      end
    end
  end

  assign req_ready = w_ready & {NUM_REQ{sys_rst_n}};
  assign w_accept  = |(req_valid & req_ready);

  always_comb begin
    w_a = '0;
    w_b = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_gnt_idx == ID_W'(i)) begin
        w_a = req_a[i*BITWIDTH +: BITWIDTH];
        w_b = req_b[i*BITWIDTH +: BITWIDTH];
      end
    end
  end

  // Stage p0: captured operand pair and owner, valid follows the acceptance.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_rr_ptr <= '0;
      r_vld_p0 <= 1'b0;
    end else begin
      r_vld_p0 <= w_accept;
      if (w_accept) begin
        r_rr_ptr <= (w_gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : PTR_W'(w_gnt_idx + 1'b1);
      end
    end
  end

  always_ff @(posedge sys_clk) begin
    if (w_accept) begin
      r_a_p0  <= w_a;
      r_b_p0  <= w_b;
      r_id_p0 <= w_gnt_idx;
    end
  end

  mult_arbiter_mult #(
    .BITWIDTH (BITWIDTH)
  ) u_mult (
    .i_a (r_a_p0),
    .i_b (r_b_p0),
    .o_y (w_y)
  );

`ifdef MULT_ARB_OUT_REG_EN
  logic                  r_vld_p1;
  logic [ID_W-1:0]       r_id_p1;
  logic [2*BITWIDTH-1:0] r_y_p1;

  // Stage p1: registered product and owner.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_vld_p1 <= 1'b0;
    end else begin
      r_vld_p1 <= r_vld_p0;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (r_vld_p0) begin
      r_id_p1 <= r_id_p0;
      r_y_p1  <= w_y;
    end
  end

  assign w_vld_out = r_vld_p1;
  assign w_id_out  = r_id_p1;
  assign resp_y    = r_y_p1;
`else
  assign w_vld_out = r_vld_p0;
  assign w_id_out  = r_id_p0;
  assign resp_y    = w_y;
`endif

  assign resp_id = w_id_out;

  always_comb begin
    resp_valid = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      resp_valid[i] = w_vld_out && (w_id_out == ID_W'(i));
    end
  end

endmodule

// File: tb/tb_mult_arbiter.sv
// Self-checking bench for mult_arbiter: directed scenarios plus randomized traffic
// against a round-robin/product scoreboard model.
module tb_mult_arbiter;

  localparam int BW = 32;
  localparam int NR = 4;
`ifdef MULT_ARB_OUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  typedef struct {
    int          id;
    logic [63:0] y;
    int          cyc;
    int          acc;
  } res_t;

  logic            sys_clk;
  logic            sys_rst_n;
  logic [NR-1:0]   req_valid;
  logic [NR-1:0]   req_ready;
  logic [NR*BW-1:0] req_a;
  logic [NR*BW-1:0] req_b;
  logic [NR-1:0]   resp_valid;
  logic [1:0]      resp_id;
  logic [2*BW-1:0] resp_y;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   m_ptr = 0;
  res_t exp_q[$];
  res_t obs_q[$];

  int            mdl_g;
  res_t          mdl_e;
  int            mon_g;
  logic [NR-1:0] mon_rdy;
  res_t          mon_e;
  res_t          mon_o;

  mult_arbiter #(
    .BITWIDTH (BW),
    .NUM_REQ  (NR)
  ) dut (
    .sys_clk    (sys_clk),
    .sys_rst_n  (sys_rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .resp_valid (resp_valid),
    .resp_id    (resp_id),
    .resp_y     (resp_y)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  // Round-robin rule: first valid index scanning upward from ptr, modulo NR.
  function automatic int model_grant(input logic [NR-1:0] v, input int ptr);
    for (int k = 0; k < NR; k++) begin
      if (v[(ptr + k) % NR]) return (ptr + k) % NR;
    end
    return -1;
  endfunction

  always @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      exp_q.delete();
      m_ptr = 0;
    end else begin
      cyc++;
      mdl_g = model_grant(req_valid, m_ptr);
      if (mdl_g >= 0) begin
        mdl_e.id  = mdl_g;
        mdl_e.y   = 64'(req_a[mdl_g*BW +: BW]) * 64'(req_b[mdl_g*BW +: BW]);
        mdl_e.cyc = cyc;
        mdl_e.acc = cyc;
        exp_q.push_back(mdl_e);
        m_ptr = (mdl_g + 1) % NR;
      end
    end
  end

  always @(negedge sys_clk) begin
    #2;
    mon_rdy = '0;
    if (sys_rst_n === 1'b1) begin
      mon_g = model_grant(req_valid, m_ptr);
      if (mon_g >= 0) mon_rdy = NR'(1 << mon_g);
    end
    checks++;
    if (req_ready !== mon_rdy) begin
      errors++;
      $display("FAIL ready t=%0t: got %b want %b", $time, req_ready, mon_rdy);
    end
    if (resp_valid !== '0) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_resp t=%0t: got resp_valid %b want 0000", $time, resp_valid);
      end else begin
        mon_e = exp_q.pop_front();
        if (resp_valid !== NR'(1 << mon_e.id) || resp_id !== 2'(mon_e.id) || resp_y !== mon_e.y) begin
          errors++;
          $display("FAIL resp t=%0t: got v=%b id=%0d y=%h want v=%b id=%0d y=%h",
                   $time, resp_valid, resp_id, resp_y, NR'(1 << mon_e.id), mon_e.id, mon_e.y);
        end
        mon_o.id  = int'(resp_id);
        mon_o.y   = resp_y;
        mon_o.cyc = cyc;
        mon_o.acc = mon_e.acc;
        obs_q.push_back(mon_o);
      end
    end
  end

  task automatic do_reset();
    @(negedge sys_clk);
    sys_rst_n = 1'b0;
    req_valid = '0;
    repeat (2) @(negedge sys_clk);
    sys_rst_n = 1'b1;
    obs_q.delete();
  endtask

  task automatic drain();
    @(negedge sys_clk);
    req_valid = '0;
    repeat (LAT + 2) @(negedge sys_clk);
    #3;
  endtask

  task automatic test_reset();
    req_valid = '1;
    #12;
    checks++;
    if (req_ready !== '0 || resp_valid !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got ready=%b resp_valid=%b want 0000/0000", req_ready, resp_valid);
    end
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    #1;
    checks++;
    if (req_ready !== 4'b0001) begin
      errors++;
      $display("FAIL reset_first_grant: got %b want 0001", req_ready);
    end
    drain();
  endtask

  task automatic test_single();
    do_reset();
    req_valid = 4'b0100;
    req_a[2*BW +: BW] = 32'hFFFF_FFFF;
    req_b[2*BW +: BW] = 32'hFFFF_FFFF;
    drain();
    checks++;
    if (obs_q.size() != 1) begin
      errors++;
      $display("FAIL single_count: got %0d results want 1", obs_q.size());
    end else begin
      checks++;
      if (obs_q[0].id != 2 || obs_q[0].y !== 64'hFFFF_FFFE_0000_0001) begin
        errors++;
        $display("FAIL single_value: got id=%0d y=%h want id=2 y=fffffffe00000001", obs_q[0].id, obs_q[0].y);
      end
      checks++;
      if (obs_q[0].cyc - obs_q[0].acc != LAT - 1) begin
        errors++;
        $display("FAIL single_latency: got %0d want %0d", obs_q[0].cyc - obs_q[0].acc + 1, LAT);
      end
    end
  endtask

  task automatic test_fairness();
    do_reset();
    for (int k = 0; k < 8; k++) begin
      if (k != 0) @(negedge sys_clk);
      req_valid = '1;
      req_a = {$urandom, $urandom, $urandom, $urandom};
      req_b = {$urandom, $urandom, $urandom, $urandom};
      #1;
      checks++;
      if (req_ready !== 4'(1 << (k % 4))) begin
        errors++;
        $display("FAIL fair_grant%0d: got %b want %b", k, req_ready, 4'(1 << (k % 4)));
      end
    end
    drain();
    checks++;
    if (obs_q.size() != 8) begin
      errors++;
      $display("FAIL fair_count: got %0d results want 8", obs_q.size());
    end else begin
      for (int k = 0; k < 8; k++) begin
        checks++;
        if (obs_q[k].id != k % 4) begin
          errors++;
          $display("FAIL fair_order%0d: got id %0d want %0d", k, obs_q[k].id, k % 4);
        end
      end
    end
  endtask

  task automatic test_wrap_skip();
    do_reset();
    req_valid = 4'b0100;
    @(negedge sys_clk);
    req_valid = 4'b0010;
    #1;
    checks++;
    if (req_ready !== 4'b0010) begin
      errors++;
      $display("FAIL wrap_grant: got %b want 0010", req_ready);
    end
    @(negedge sys_clk);
    req_valid = 4'b1111;
    #1;
    checks++;
    if (req_ready !== 4'b0100) begin
      errors++;
      $display("FAIL wrap_ptr: got %b want 0100", req_ready);
    end
    drain();
  endtask

  task automatic test_reset_midflight();
    int cnt;
    do_reset();
    req_valid = 4'b0001;
    req_a[BW-1:0] = 32'd7;
    req_b[BW-1:0] = 32'd6;
    @(negedge sys_clk);
    req_valid = '0;
    sys_rst_n = 1'b0;
    repeat (2) @(negedge sys_clk);
    sys_rst_n = 1'b1;
    obs_q.delete();
    cnt = 0;
    for (int k = 0; k < 6; k++) begin
      #3;
      if (resp_valid !== '0) cnt++;
      @(negedge sys_clk);
    end
    checks++;
    if (cnt != 0) begin
      errors++;
      $display("FAIL midflight_discard: got %0d resp_valid cycles want 0", cnt);
    end
    req_valid = 4'b0001;
    req_a[BW-1:0] = 32'd3;
    req_b[BW-1:0] = 32'd5;
    drain();
    checks++;
    if (obs_q.size() != 1 || obs_q[0].y !== 64'd15) begin
      errors++;
      $display("FAIL midflight_restart: got %0d results want 1 with y=15", obs_q.size());
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int i = 0; i < 16; i++) begin
      if (i != 0) @(negedge sys_clk);
      req_valid = 4'b0001;
      req_a[BW-1:0] = 32'(i);
      req_b[BW-1:0] = 32'(i + 1);
    end
    drain();
    checks++;
    if (obs_q.size() != 16) begin
      errors++;
      $display("FAIL b2b_count: got %0d results want 16", obs_q.size());
    end else begin
      for (int i = 0; i < 16; i++) begin
        checks++;
        if (obs_q[i].id != 0 || obs_q[i].y !== 64'(i * (i + 1)) || obs_q[i].cyc != obs_q[0].cyc + i) begin
          errors++;
          $display("FAIL b2b_%0d: got id=%0d y=%0d cyc+%0d want id=0 y=%0d cyc+%0d",
                   i, obs_q[i].id, obs_q[i].y, obs_q[i].cyc - obs_q[0].cyc, i * (i + 1), i);
        end
      end
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int k = 0; k < 300; k++) begin
      if (k != 0) @(negedge sys_clk);
      req_valid = 4'($urandom);
      for (int r = 0; r < NR; r++) begin
        req_a[r*BW +: BW] = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : $urandom;
        req_b[r*BW +: BW] = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : $urandom;
      end
    end
    drain();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL random_drain: got %0d results outstanding want 0", exp_q.size());
    end
  endtask

  initial begin
    sys_rst_n = 1'b0;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    test_reset();
    test_single();
    test_fairness();
    test_wrap_skip();
    test_reset_midflight();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
